// File: rtl/pattern_pkg.sv
// pattern_pkg: shared state encoding, pattern indices and select width for the test-pattern datapath
package pattern_pkg;
    localparam int SEL_W = 2;
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
    localparam logic [SEL_W-1:0] PAT_FADE    = 2'd0;
    localparam logic [SEL_W-1:0] PAT_BARS    = 2'd1;
    localparam logic [SEL_W-1:0] PAT_CHECKER = 2'd2;
    localparam logic [SEL_W-1:0] PAT_SOLID   = 2'd3;
endpackage

// File: rtl/vs_edge_detect.sv
// vs_edge_detect: combinational VS falling-edge strobe plus its one-cycle registered pulse
module vs_edge_detect (
    input  logic I_pxl_clk,
    input  logic I_rst_n,
    input  logic I_vs,
    output logic O_fs,
    output logic O_frame_start
);
    logic vs_prev;
    assign O_fs = vs_prev & ~I_vs;
    always_ff @(posedge I_pxl_clk)
        if (!I_rst_n) begin
            vs_prev       <= 1'b0;
            O_frame_start <= 1'b0;
        end else begin
            vs_prev       <= I_vs;
            O_frame_start <= O_fs;
        end
endmodule

// File: rtl/pattern_scheduler.sv
// pattern_scheduler: frame-synchronous pattern select and fade ramp sequencer; PATTERN_SCHED_FRAME_CNT_EN adds O_frame_count
module pattern_scheduler
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int FADE_FRAMES  = 30,
    parameter int FADE_STEP    = 8
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst_n,
    input  logic             I_vs,
    input  logic             I_enable,
    input  logic             I_auto,
    input  logic             I_next,
    output logic [SEL_W-1:0] O_pattern_sel,
    output logic [7:0]       O_fade_value,
    output logic             O_fade_dir,
`ifdef PATTERN_SCHED_FRAME_CNT_EN
    output logic [15:0]      O_frame_count,
`endif
    output logic             O_frame_start
);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [15:0]      HOLD_LAST = 16'(HOLD_FRAMES - 1);
    localparam logic [7:0]       FADE_LAST = 8'(FADE_FRAMES - 1);
    state_t           state, state_n;
    logic             fs, pending, pending_n, adv, dir_n;
    logic [SEL_W-1:0] sel_n;
    logic [15:0]      hold_cnt, hold_n, prod;
    logic [7:0]       fade_cnt, fade_cnt_n, sat, value_n;
    vs_edge_detect u_vs_edge (
        .I_pxl_clk     (I_pxl_clk),
        .I_rst_n       (I_rst_n),
        .I_vs          (I_vs),
        .O_fs          (fs),
        .O_frame_start (O_frame_start)
    );
    always_comb begin
        state_n    = state;
        sel_n      = O_pattern_sel;
        hold_n     = hold_cnt;
        pending_n  = pending;
        fade_cnt_n = fade_cnt;
        value_n    = O_fade_value;
        dir_n      = O_fade_dir;
        prod       = 16'(fade_cnt) * 16'(FADE_STEP);
        sat        = prod > 16'd255 ? 8'd255 : prod[7:0];
        adv        = (I_auto && hold_cnt == HOLD_LAST) || pending;
        if (state == S_IDLE || !I_enable) begin
            state_n    = I_enable ? S_RUN : S_IDLE;
            hold_n     = '0;
            pending_n  = 1'b0;
            fade_cnt_n = '0;
            value_n    = '0;
            dir_n      = 1'b0;
        end else if (fs) begin
            sel_n      = adv ? (O_pattern_sel == SEL_LAST ? '0 : O_pattern_sel + SEL_W'(1)) : O_pattern_sel;
            hold_n     = adv ? '0 : (hold_cnt == HOLD_LAST ? hold_cnt : hold_cnt + 16'd1);
            pending_n  = I_next;
            value_n    = O_fade_dir ? 8'd255 - sat : sat;
            fade_cnt_n = fade_cnt == FADE_LAST ? '0 : fade_cnt + 8'd1;
            dir_n      = O_fade_dir ^ (fade_cnt == FADE_LAST);
        end else begin
            pending_n  = pending | I_next;
        end
    end
    always_ff @(posedge I_pxl_clk)
        if (!I_rst_n) begin
            state         <= S_IDLE;
            O_pattern_sel <= PAT_FADE;
            hold_cnt      <= '0;
            pending       <= 1'b0;
            fade_cnt      <= '0;
            O_fade_value  <= '0;
            O_fade_dir    <= 1'b0;
        end else begin
            state         <= state_n;
            O_pattern_sel <= sel_n;
            hold_cnt      <= hold_n;
            pending       <= pending_n;
            fade_cnt      <= fade_cnt_n;
            O_fade_value  <= value_n;
            O_fade_dir    <= dir_n;
        end
`ifdef PATTERN_SCHED_FRAME_CNT_EN
    always_ff @(posedge I_pxl_clk)
        O_frame_count <= (!I_rst_n || state == S_IDLE || !I_enable) ? '0 : O_frame_count + 16'(fs);
`endif
endmodule

// File: tb/tb_pattern_scheduler.sv
// tb_pattern_scheduler: directed and randomized checks of pattern_scheduler against a frame-level reference model
module tb_pattern_scheduler;
    localparam int NP = 4, HF = 3, FF = 30, FS = 8;
    logic clk = 1'b0, rst_n = 1'b0, vs = 1'b1, en = 1'b0, au = 1'b0, nx = 1'b0;
    logic [1:0] sel;
    logic [7:0] fv;
    logic       dir, fst;
`ifdef PATTERN_SCHED_FRAME_CNT_EN
    logic [15:0] fcnt;
`endif
    int tests = 0, fails = 0;
    int m_sel, m_since, m_n, m_val, m_cnt;
    bit m_run, m_pend, m_dir, m_fst, m_vp;
    always #5 clk = ~clk;
    pattern_scheduler #(.NUM_PATTERNS(NP), .HOLD_FRAMES(HF), .FADE_FRAMES(FF), .FADE_STEP(FS)) dut (
        .I_pxl_clk     (clk),
        .I_rst_n       (rst_n),
        .I_vs          (vs),
        .I_enable      (en),
        .I_auto        (au),
        .I_next        (nx),
        .O_pattern_sel (sel),
        .O_fade_value  (fv),
        .O_fade_dir    (dir),
`ifdef PATTERN_SCHED_FRAME_CNT_EN
        .O_frame_count (fcnt),
`endif
        .O_frame_start (fst)
    );
    function automatic int fade_of(int n);
        int p;
        p = (n % FF) * FS;
        if (p > 255) p = 255;
        return ((n / FF) % 2) ? 255 - p : p;
    endfunction
    task automatic chk(string tag, integer got, integer exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic model();
        bit fs;
        fs = m_vp && !vs;
        if (!rst_n) begin
            m_sel = 0; m_since = 0; m_pend = 0; m_n = 0; m_val = 0;
            m_dir = 0; m_fst = 0; m_vp = 0; m_run = 0; m_cnt = 0;
        end else begin
            m_fst = fs;
            m_vp  = vs;
            if (!m_run || !en) begin
                m_run = en; m_since = 0; m_pend = 0; m_n = 0; m_val = 0; m_dir = 0; m_cnt = 0;
            end else if (fs) begin
                if ((au && m_since >= HF - 1) || m_pend) begin
                    m_sel   = (m_sel + 1) % NP;
                    m_since = 0;
                end else m_since++;
                m_pend = nx;
                m_val  = fade_of(m_n);
                m_n++;
                m_dir  = (m_n / FF) % 2;
                m_cnt  = (m_cnt + 1) % 65536;
            end else m_pend = m_pend || nx;
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        model();
        #1;
        chk("sel", sel, m_sel);
        chk("fade_value", fv, m_val);
        chk("fade_dir", dir, m_dir);
        chk("frame_start", fst, m_fst);
`ifdef PATTERN_SCHED_FRAME_CNT_EN
        chk("frame_count", fcnt, m_cnt);
`endif
    endtask
    task automatic frame(int hi, int lo, bit next_fs, int p_next);
        vs = 1'b1;
        repeat (hi) begin
            nx = ($urandom_range(99) < p_next);
            cyc();
        end
        vs = 1'b0;
        nx = next_fs;
        cyc();
        nx = 1'b0;
        repeat (lo - 1) cyc();
    endtask
    initial begin
        int s0, k;
        rst_n = 1'b0; vs = 1'b1;
        cyc();
        vs = 1'b0;
        cyc(); cyc();
        chk("rst_sel", sel, 0); chk("rst_fade", fv, 0); chk("rst_dir", dir, 0); chk("rst_fstart", fst, 0);
        rst_n = 1'b1;
        cyc();
        chk("rst_no_fstart", fst, 0);
        en = 1'b1; au = 1'b1;
        cyc();
        for (int f = 1; f <= 32; f++) begin
            frame(4, 3, 1'b0, 0);
            if (f == 1) begin chk("fade1", fv, 0); chk("dir1", dir, 0); end
            if (f % 3 == 0 && f <= 12) chk("auto_rotate", sel, (f / 3) % 4);
            if (f == 14) chk("auto14", sel, 0);
            if (f == 30) begin chk("fade30", fv, 232); chk("dir30", dir, 1); end
            if (f == 31) chk("fade31", fv, 255);
            if (f == 32) chk("fade32", fv, 247);
        end
        au = 1'b0;
        frame(4, 3, 1'b0, 0);
        s0 = sel;
        vs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nx = (i % 2 == 0);
            cyc();
        end
        vs = 1'b0; nx = 1'b1;
        cyc();
        nx = 1'b0;
        chk("manual_first", sel, (s0 + 1) % NP);
        repeat (2) cyc();
        frame(4, 3, 1'b0, 0);
        chk("manual_second", sel, (s0 + 2) % NP);
        frame(4, 3, 1'b0, 0);
        chk("manual_hold", sel, (s0 + 2) % NP);
        s0 = sel; au = 1'b1;
        frame(4, 3, 1'b0, 100);
        chk("collision", sel, (s0 + 1) % NP);
        frame(4, 3, 1'b0, 0);
        chk("collision_once", sel, (s0 + 1) % NP);
        for (int f = 0; f < 60; f++) begin
            au = 1'($urandom_range(1));
            en = ($urandom_range(9) != 0);
            frame($urandom_range(2, 5), $urandom_range(1, 4), 1'($urandom_range(1)), $urandom_range(30));
        end
        en = 1'b1; au = 1'b0;
        k = 0;
        while (sel != 2 && k < 20) begin
            frame(3, 2, 1'b1, 0);
            k++;
        end
        chk("reach_sel2", sel, 2);
        frame(3, 2, 1'b0, 0);
        en = 1'b0;
        cyc();
        chk("dis_sel", sel, 2); chk("dis_fade", fv, 0); chk("dis_dir", dir, 0);
        frame(3, 2, 1'b0, 0);
        chk("idle_sel", sel, 2);
        en = 1'b1;
        cyc();
        frame(4, 3, 1'b0, 0);
        chk("restart_fade", fv, 0); chk("restart_sel", sel, 2);
        frame(4, 3, 1'b0, 0);
        chk("restart_fade2", fv, 8);
        vs = 1'b1;
        cyc(); cyc();
        rst_n = 1'b0; vs = 1'b0;
        cyc(); cyc();
        chk("midrst_sel", sel, 0); chk("midrst_fade", fv, 0); chk("midrst_fstart", fst, 0);
        rst_n = 1'b1;
        cyc();
        chk("midrst_no_fstart", fst, 0);
        repeat (3) frame(4, 3, 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Frame-synchronous sequencer for the DVI test-pattern datapath at 74.25 MHz (1280x720 @ 60 FPS).
- Selects which pattern generator drives the TX mux, either by auto-rotation or manual advance.
- Produces the fade ramp value and direction consumed by the fade generator.
- All changes take effect only at frame boundaries (VS falling edge), so no mid-frame tearing.

Parameters:
- NUM_PATTERNS, 4, number of selectable patterns (2..4); sel wraps NUM_PATTERNS-1 -> 0
- HOLD_FRAMES, 120, frames per pattern in auto mode (1..65535)
- FADE_FRAMES, 30, frames per fade half-cycle (2..255)
- FADE_STEP, 8, fade increment per frame (1..255)

Ports:
- I_pxl_clk  in  1  pixel clock, all logic on rising edge
- I_rst_n  in  1  reset, synchronous, active-low
- I_vs  in  1  vertical sync from timing generator; falling edge = new frame
- I_enable  in  1  1 = scheduler runs; 0 = idle
- I_auto  in  1  1 = auto-rotate every HOLD_FRAMES; 0 = manual only
- I_next  in  1  single-cycle manual advance request
- O_pattern_sel  out  2  active pattern index
- O_fade_value  out  8  fade colour value for current frame
- O_fade_dir  out  1  0 = ramp up, 1 = ramp down
- O_frame_start  out  1  one-cycle pulse per detected frame

Behaviour:
- Reset: sync active-low; at the first rising edge with I_rst_n=0 every register clears:
  - O_pattern_sel=0, O_fade_value=0, O_fade_dir=0, O_frame_start=0
  - internal counters, pending flag and vs_prev=0; state=S_IDLE
- Reset asserted mid-operation clears everything at that edge; no frame event is processed that cycle.
- Edge detect: vs_prev registers I_vs. fs = vs_prev & ~I_vs. O_frame_start is registered fs, i.e. high exactly one cycle after the cycle in which I_vs is first sampled low.
- Frame counters and pattern/fade updates act on fs. Updated outputs are visible in the same cycle as O_frame_start.
- State S_IDLE:
  - O_pattern_sel holds; hold_cnt, fade_cnt, pending, O_fade_value and O_fade_dir are cleared.
  - I_enable=1 -> S_RUN. No frame action in the transition cycle.
- State S_RUN, on fs:
  - hold_cnt increments.
  - Advance when (I_auto & hold_cnt==HOLD_FRAMES-1) | pending.
  - Advance means: sel = (sel==NUM_PATTERNS-1) ? 0 : sel+1; hold_cnt=0; pending=0.
  - Auto expiry and pending on the same fs advance sel exactly once.
- I_next in S_RUN sets pending. Multiple pulses within one frame collapse to one advance.
- I_next coincident with fs is latched as pending and applied at the following fs, not the current one.
- Fade, on fs in S_RUN:
  - O_fade_value = dir ? 255 - fade_cnt*FADE_STEP : fade_cnt*FADE_STEP.
  - Product is computed 16-bit wide and saturated to 255 before the subtract.
  - Then fade_cnt increments; when fade_cnt==FADE_FRAMES-1 it wraps to 0 and O_fade_dir toggles.
- I_enable=0 in any state -> S_IDLE on the next edge, with the S_IDLE clears applied. O_pattern_sel is retained.
- I_auto may change at any time. Switching to 0 freezes auto expiry but hold_cnt keeps counting, saturating at HOLD_FRAMES-1.

Optional Feature:
- Macro: PATTERN_SCHED_FRAME_CNT_EN
- Defined:
  - Adds port O_frame_count out 16, a free-running count of fs events in S_RUN.
  - Wraps 65535 -> 0.
  - Cleared by reset and in S_IDLE.
  - Updates in the same cycle as O_frame_start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pattern_pkg:
  - state encoding S_IDLE=0, S_RUN=1
  - pattern index constants PAT_FADE=0, PAT_BARS=1, PAT_CHECKER=2, PAT_SOLID=3
  - pattern select width 2
- Sub-module vs_edge_detect: registered falling-edge pulse of I_vs.
  - Reused by the fade generator and the future frame buffer controller.

Test Plan:
- Reset: hold I_rst_n=0 two cycles mid-frame -> all outputs 0 at the next edge. No O_frame_start even when I_vs falls during reset.
- Auto rotate: HOLD_FRAMES=3, NUM_PATTERNS=4, I_auto=1, 14 frames -> O_pattern_sel advances after every 3rd frame: 0→1→2→3→0.
- Fade: FADE_FRAMES=30, FADE_STEP=8.
  - Frames 1..30 give values 0,8,...,232; dir toggles to 1 after frame 30.
  - Frame 31 gives 255; frame 32 gives 247.
- Manual: I_auto=0; three I_next pulses in one frame, plus one I_next on the fs cycle of the next frame -> two single advances (0→1, then 1→2), each on a successive fs.
- Collision: auto expiry and pending on the same fs -> sel advances by exactly 1.
- Disable mid-run: I_enable=0 at sel=2 -> S_IDLE; fade value/dir cleared, sel stays 2. Re-enable -> counting restarts from 0. With PATTERN_SCHED_FRAME_CNT_EN, O_frame_count=0.
